spi_coeff_rx: RTL and testbench

SPI_COEFF_RX -- requirements
Module: spi_coeff_rx

---
 rtl/spi_coeff_pkg.sv | 15 +
 rtl/sync2.sv | 24 ++
 rtl/spi_coeff_rx.sv | 123 ++++++++++++
 tb/tb_spi_coeff_rx.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_coeff_pkg.sv
// Shared constants and state encoding for the SPI coefficient receiver.
package spi_coeff_pkg;

  localparam int unsigned FRAME_BITS  = 336;
  localparam int unsigned HDR_W       = 16;
  localparam logic [HDR_W-1:0] HEADER_WORD = 16'hA55A;
  localparam int unsigned CNT_W       = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input; reset value selectable.
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Double-register the asynchronous input into the clk domain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_coeff_rx.sv
// SPI mode-0 slave receiving one fixed-length coefficient frame per cs_n window.
module spi_coeff_rx
  import spi_coeff_pkg::*;
#(
  parameter int unsigned       FRAME_BITS = spi_coeff_pkg::FRAME_BITS,
  parameter logic [HDR_W-1:0]  HEADER     = spi_coeff_pkg::HEADER_WORD
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sck,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic [FRAME_BITS-1:0] data,
  output logic                  data_valid,
  output logic                  frame_err,
  output logic                  busy
);

  logic sck_s2, cs_s2, mosi_s2;
  logic sck_s3, cs_s3;
  logic sck_rise, cs_fall, cs_rise;
  logic frame_full, header_ok;

  logic [1:0]            warm;
  state_t                state;
  logic                  armed;
  logic                  overrun;
  logic [CNT_W-1:0]      count;
  logic [FRAME_BITS-1:0] shift_reg;

  sync2 #(.RST_VAL(1'b0)) u_sync_sck  (.clk(clk), .reset(reset), .d(sck),  .q(sck_s2));
  sync2 #(.RST_VAL(1'b1)) u_sync_cs   (.clk(clk), .reset(reset), .d(cs_n), .q(cs_s2));
  sync2 #(.RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .reset(reset), .d(mosi), .q(mosi_s2));

  // Third stage for edge detection on the synchronized sck and cs_n.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sck_s3 <= 1'b0;
      cs_s3  <= 1'b1;
    end else begin
      sck_s3 <= sck_s2;
      cs_s3  <= cs_s2;
    end
  end

  assign sck_rise   = sck_s2 & ~sck_s3;
  assign cs_fall    = ~cs_s2 & cs_s3;
  assign cs_rise    = cs_s2 & ~cs_s3;
  assign frame_full = (count == CNT_W'(FRAME_BITS));
  assign header_ok  = (shift_reg[FRAME_BITS-1 -: HDR_W] == HEADER);

  // The synchronizer flops come out of reset holding their reset values, not
  // the real pins; hold off arming until the pipeline has flushed so a cs_n
  // held low through reset cannot look like a fresh high-then-low sequence.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      warm <= 2'd0;
    end else if (warm != 2'd3) begin
      warm <= warm + 2'd1;
    end
  end

  // Frame FSM: arm, shift bits on sck rises, then judge the frame for one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      armed      <= 1'b0;
      overrun    <= 1'b0;
      count      <= '0;
      shift_reg  <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (cs_fall && armed) begin
            state   <= SHIFT;
            armed   <= 1'b0;
            count   <= '0;
            overrun <= 1'b0;
            busy    <= 1'b1;
          end else if (cs_s2 && (warm == 2'd3)) begin
            armed <= 1'b1;
          end
        end
        SHIFT: begin
          // A bit edge coinciding with cs_n rise is still taken into the frame.
          if (sck_rise) begin
            if (frame_full) begin
              overrun <= 1'b1;
            end else begin
              shift_reg <= {shift_reg[FRAME_BITS-2:0], mosi_s2};
              count     <= count + CNT_W'(1);
            end
          end
          if (cs_rise) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (frame_full && !overrun && header_ok) begin
            data       <= shift_reg;
            data_valid <= 1'b1;
          end else begin
            frame_err  <= 1'b1;
          end
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_coeff_rx.sv
// Scoreboard bench for spi_coeff_rx: bit-level SPI driver, frame-level model.
module tb_spi_coeff_rx;

  localparam int unsigned FB = 336;

  logic          clk   = 1'b0;
  logic          reset = 1'b0;
  logic          sck   = 1'b0;
  logic          cs_n  = 1'b1;
  logic          mosi  = 1'b0;
  logic [FB-1:0] data;
  logic          data_valid;
  logic          frame_err;
  logic          busy;

  spi_coeff_rx #(.FRAME_BITS(FB), .HEADER(16'hA55A)) dut (
    .clk(clk), .reset(reset), .sck(sck), .cs_n(cs_n), .mosi(mosi),
    .data(data), .data_valid(data_valid), .frame_err(frame_err), .busy(busy)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit            ok;
    logic [FB-1:0] d;
    int            at;
  } exp_t;

  exp_t          exp_q[$];
  logic [FB-1:0] model_data = '0;
  int            n_tests = 0;
  int            n_fail  = 0;

  task automatic check(input string name, input logic [FB-1:0] act, input logic [FB-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic void vec2q(input logic [FB-1:0] v, output bit q[$]);
    q.delete();
    for (int i = FB - 1; i >= 0; i--) q.push_back(v[i]);
  endfunction

  function automatic logic [FB-1:0] rand_frame(input logic [15:0] hdr);
    logic [FB-1:0] v;
    for (int i = 0; i < FB; i++) v[i] = 1'($urandom_range(0, 1));
    v[FB-1 -: 16] = hdr;
    return v;
  endfunction

  // Frame-level reference: accept iff exactly FB bits and the leading 16 bits match.
  task automatic predict(input bit bits[$]);
    logic [FB-1:0] v;
    bit            ok;
    v = '0;
    foreach (bits[i]) v = {v[FB-2:0], bits[i]};
    ok = (bits.size() == FB) && (v[FB-1 -: 16] == 16'hA55A);
    if (ok) model_data = v;
    exp_q.push_back('{ok: ok, d: model_data, at: cyc + 4});
  endtask

  // Mode-0 frame: mosi changes with sck low, last rise is 'tail' clocks before cs_n rise.
  task automatic send_frame(input bit bits[$], input int h, input int tail, input bit capture);
    int n;
    n = bits.size();
    cs_n = 1'b0;
    wait_clk(h);
    for (int i = 0; i < n; i++) begin
      mosi = bits[i];
      wait_clk(h);
      sck = 1'b1;
      if (capture && i == 8) check("busy_mid_frame", FB'(busy), FB'(1));
      if (i < n - 1) begin
        wait_clk(h);
        sck = 1'b0;
      end
    end
    if (tail >= h) begin
      wait_clk(h);
      sck = 1'b0;
      wait_clk(tail - h);
    end else begin
      wait_clk(tail);
    end
    cs_n = 1'b1;
    if (capture) predict(bits);
    if (sck) begin
      wait_clk(h);
      sck = 1'b0;
    end
    mosi = 1'b0;
    wait_clk(12);
  endtask

  // Monitor: every output pulse must match the head of the expectation queue.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset && (data_valid || frame_err)) begin
      n_tests++;
      if (data_valid && frame_err) begin
        n_fail++;
        $display("FAIL pulse_exclusive: data_valid=1 frame_err=1 at cycle %0d, need at most one", cyc);
      end
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pulse: data_valid=%0b frame_err=%0b at cycle %0d, no frame pending",
                 data_valid, frame_err, cyc);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind_valid", FB'(data_valid), FB'(e.ok));
        check("pulse_data", data, e.d);
        check("pulse_cycle", FB'(cyc), FB'(e.at));
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, pending=%0d", exp_q.size());
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [FB-1:0] f, g;
    bit            q[$];
    int            h, t;

    wait_clk(5);
    check("reset_data", data, '0);
    check("reset_data_valid", FB'(data_valid), FB'(0));
    check("reset_frame_err", FB'(frame_err), FB'(0));
    check("reset_busy", FB'(busy), FB'(0));
    reset = 1'b1;
    wait_clk(8);

    // Known coefficient frame.
    f = '0;
    f[FB-1 -: 16] = 16'hA55A;
    for (int k = 1; k <= 15; k++) f[239 - 16 * (k - 1) -: 16] = 16'(k);
    vec2q(f, q);
    send_frame(q, 5, 10, 1'b1);
    wait_clk(4);
    check("coef_last", FB'(data[15:0]), FB'(16'h000F));
    check("coef_first", FB'(data[239:224]), FB'(16'h0001));

    // Wrong header.
    g = f;
    g[FB-1 -: 16] = 16'hA55B;
    vec2q(g, q);
    send_frame(q, 5, 10, 1'b1);

    // Short and long frames.
    vec2q(rand_frame(16'hA55A), q);
    void'(q.pop_back());
    send_frame(q, 5, 10, 1'b1);
    vec2q(rand_frame(16'hA55A), q);
    q.push_back(1'b1);
    send_frame(q, 5, 10, 1'b1);

    // Reset mid-frame after 100 bits, then a full good frame.
    vec2q(rand_frame(16'hA55A), q);
    cs_n = 1'b0;
    wait_clk(5);
    for (int i = 0; i < 100; i++) begin
      mosi = q[i];
      wait_clk(5);
      sck = 1'b1;
      wait_clk(5);
      sck = 1'b0;
    end
    reset = 1'b0;
    model_data = '0;
    wait_clk(4);
    check("reset_abort_data", data, '0);
    mosi = 1'b0;
    cs_n = 1'b1;
    wait_clk(4);
    reset = 1'b1;
    wait_clk(10);
    vec2q(rand_frame(16'hA55A), q);
    send_frame(q, 5, 10, 1'b1);

    // Reset released with cs_n low: that window must be ignored.
    reset = 1'b0;
    cs_n  = 1'b0;
    model_data = '0;
    wait_clk(4);
    reset = 1'b1;
    vec2q(rand_frame(16'hA55A), q);
    send_frame(q, 5, 10, 1'b0);
    check("no_capture_unarmed", data, '0);
    vec2q(rand_frame(16'hA55A), q);
    send_frame(q, 5, 10, 1'b1);

    // Last sck rise one clock, and zero clocks, before cs_n rise.
    vec2q(rand_frame(16'hA55A), q);
    send_frame(q, 5, 1, 1'b1);
    vec2q(rand_frame(16'hA55A), q);
    send_frame(q, 4, 0, 1'b1);

    // Randomized good frames with varied sck rate and cs_n tail.
    for (int r = 0; r < 4; r++) begin
      h = $urandom_range(2, 5);
      t = $urandom_range(0, 2 * h);
      vec2q(rand_frame(16'hA55A), q);
      send_frame(q, h, t, 1'b1);
    end

    // Randomized single-bit header corruption.
    vec2q(rand_frame(16'hA55A ^ (16'h1 << $urandom_range(0, 15))), q);
    send_frame(q, 3, 4, 1'b1);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) wait_clk(1);
    check("queue_drained", FB'(exp_q.size()), '0);
    check("final_data", data, model_data);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
